// File: rtl/adc_spi_multi.sv
// adc_spi_multi: read-only SPI controller for multi-channel serial ADCs with a shared CS/SCLK.
// Define ADC_SPI_OVERRUN_CNT_EN to add a saturating 16-bit overrun_count output.
module adc_spi_multi #(
  parameter int NUM_CHANNELS                = 2,
  parameter int FRAME_BITS                  = 16,
  parameter int DATA_BITS                   = 12,
  parameter int CLOCKS_PER_BIT              = 4,
  parameter int CLOCKS_BEFORE_DATA          = 5,
  parameter int CLOCKS_AFTER_DATA           = 5,
  parameter int CLOCKS_BETWEEN_TRANSACTIONS = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cont,
  input  logic                              start,
  output logic                              cs,
  output logic                              sclk,
  input  logic [NUM_CHANNELS-1:0]           sdin,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] dout,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic                              overrun,
`ifdef ADC_SPI_OVERRUN_CNT_EN
  output logic [15:0]                       overrun_count,
`endif
  output logic                              busy
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(CLOCKS_PER_BIT, CLOCKS_BEFORE_DATA),
                                max2(CLOCKS_AFTER_DATA, CLOCKS_BETWEEN_TRANSACTIONS));
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLOCKS_BETWEEN_TRANSACTIONS - 1);
  localparam logic [CNT_W-1:0] FRONT_LAST = CNT_W'(CLOCKS_BEFORE_DATA - 1);
  localparam logic [CNT_W-1:0] BACK_LAST  = CNT_W'(CLOCKS_AFTER_DATA - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF       = CNT_W'(CLOCKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] SAMPLE     = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_FRONT_PORCH,
    S_SHIFTING,
    S_BACK_PORCH
  } state_t;

  state_t                                    state_q, state_d;
  logic [CNT_W-1:0]                          cnt_q, cnt_d;
  logic [BIT_W-1:0]                          bit_q, bit_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    shift_q, shift_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0]         dout_q, dout_d;
  logic                                      valid_q, valid_d;
  logic                                      overrun_q, overrun_d;
  logic                                      pend_q, pend_d;
  logic                                      cs_q, cs_d;
  logic                                      sclk_q, sclk_d;
  logic                                      busy_q, busy_d;
  logic                                      frame_end;
`ifdef ADC_SPI_OVERRUN_CNT_EN
  logic [15:0]                               ovc_q, ovc_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    pend_d    = pend_q | start;
    frame_end = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          if (cont || pend_q) begin
            state_d = S_FRONT_PORCH;
            cnt_d   = '0;
            pend_d  = start;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FRONT_PORCH: begin
        if (cnt_q == FRONT_LAST) begin
          state_d = S_SHIFTING;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFTING: begin
        // Sample one cycle before SCLK rises, so the ADC output has been stable all low phase.
        if (cnt_q == SAMPLE) begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            shift_d[c] = {shift_q[c][DATA_BITS-2:0], sdin[c]};
          end
        end
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d   = S_BACK_PORCH;
            frame_end = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BACK_PORCH: begin
        if (cnt_q == BACK_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Handshake: dout transfers when dout_valid & dout_ready; a same-cycle load keeps valid high.
    if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
    if (frame_end) begin
      if (!valid_q || dout_ready) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          dout_d[c*DATA_BITS +: DATA_BITS] = shift_q[c];
        end
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    cs_d   = (state_d == S_HOLD);
    sclk_d = !((state_d == S_SHIFTING) && (cnt_d < HALF));
    busy_d = (state_d != S_HOLD);
  end

`ifdef ADC_SPI_OVERRUN_CNT_EN
  always_comb begin
    ovc_d = ovc_q;
    if (overrun_d && (ovc_q != 16'hFFFF)) begin
      ovc_d = ovc_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      pend_q    <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
      busy_q    <= 1'b0;
`ifdef ADC_SPI_OVERRUN_CNT_EN
      ovc_q     <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      pend_q    <= pend_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
`ifdef ADC_SPI_OVERRUN_CNT_EN
      ovc_q     <= ovc_d;
`endif
    end
  end

  assign cs         = cs_q;
  assign sclk       = sclk_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;
`ifdef ADC_SPI_OVERRUN_CNT_EN
  assign overrun_count = ovc_q;
`endif

endmodule

// File: tb/tb_adc_spi_multi.sv
// Self-checking bench for adc_spi_multi: serial ADC model, expected-result queue, directed scenarios.
`timescale 1ns/1ps
module tb_adc_spi_multi;
  localparam int NC = 2;
  localparam int FB = 16;
  localparam int DB = 12;
  localparam int W  = NC * DB;

  logic          clk = 1'b0;
  logic          rst;
  logic          cont;
  logic          start;
  logic          cs;
  logic          sclk;
  logic [NC-1:0] sdin;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          overrun;
  logic          busy;
`ifdef ADC_SPI_OVERRUN_CNT_EN
  logic [15:0]   overrun_count;
`endif

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W-1:0]  exp_q[$];
  logic [FB-1:0] frame_val [NC];
  int            bit_idx;
  bit            auto_push;
  int            ov_seen = 0;

  adc_spi_multi #(
    .NUM_CHANNELS(NC), .FRAME_BITS(FB), .DATA_BITS(DB), .CLOCKS_PER_BIT(4),
    .CLOCKS_BEFORE_DATA(5), .CLOCKS_AFTER_DATA(5), .CLOCKS_BETWEEN_TRANSACTIONS(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cont(cont),
    .start(start),
    .cs(cs),
    .sclk(sclk),
    .sdin(sdin),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun(overrun),
`ifdef ADC_SPI_OVERRUN_CNT_EN
    .overrun_count(overrun_count),
`endif
    .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ADC model: MSB presented at CS fall, next bit after every SCLK rise
  always @(negedge cs) begin
    bit_idx = 0;
    if (auto_push) exp_q.push_back(exp_word());
  end
  always @(posedge sclk) if (cs == 1'b0) bit_idx++;
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      sdin[c] = (bit_idx < FB) ? frame_val[c][FB-1-bit_idx] : 1'b0;
    end
  end

  function automatic logic [W-1:0] exp_word();
    logic [W-1:0] e;
    for (int c = 0; c < NC; c++) e[c*DB +: DB] = frame_val[c][DB-1:0];
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (overrun === 1'b1) ov_seen++;
    if (rst === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (exp_q.size() == 0) check_val("sb_unexpected_out", 0, 1);
      else check_val("sb_dout", dout, exp_q.pop_front());
    end
  end

  // Driver tasks (called #1 after a rising edge)
  task automatic wait_cs(input logic level, input int limit, input string tag);
    int n = 0;
    while (cs !== level && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (cs !== level) check_val(tag, cs, level);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic randomize_frame();
    for (int c = 0; c < NC; c++) frame_val[c] = 16'($urandom);
  endtask

  task automatic count_frames(input int cycles, output int falls, output int tail);
    logic prev = cs;
    falls = 0;
    tail  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (prev && !cs) falls++;
      if (cs) tail++;
      else tail = 0;
      prev = cs;
    end
  endtask

  initial begin
    int n, falls, tail, ov0;
    logic [W-1:0] a_word, e_word;
    rst = 1'b1; cont = 1'b0; start = 1'b0; dout_ready = 1'b0; auto_push = 1'b0; bit_idx = 0;
    for (int c = 0; c < NC; c++) frame_val[c] = '0;
    repeat (3) @(posedge clk); #1;
    check_val("rst_cs", cs, 1);
    check_val("rst_sclk", sclk, 1);
    check_val("rst_valid", dout_valid, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_busy", busy, 0);
    rst = 1'b0;

    // Continuous polling, ready held high
    frame_val[0] = 16'h0ABC; frame_val[1] = 16'h0123;
    dout_ready = 1'b1; auto_push = 1'b1; ov0 = ov_seen; cont = 1'b1;
    wait_cs(0, 100, "cs_fall_first");
    n = 1;
    while (n < 1000) begin @(posedge clk); #1; if (cs) break; n++; end
    check_val("cs_low_cycles", n, 74);
    n = 1;
    while (n < 1000) begin @(posedge clk); #1; if (!cs) break; n++; end
    check_val("cs_high_gap", n, 10);
    for (int k = 0; k < 4; k++) begin
      wait_cs(1, 200, "cs_rise_cont");
      randomize_frame();
      wait_cs(0, 50, "cs_fall_cont");
    end
    wait_cs(1, 200, "cs_rise_last");
    cont = 1'b0; auto_push = 1'b0;
    repeat (30) @(posedge clk); #1;
    check_val("cont_stop_cs", cs, 1);
    check_val("cont_sb_drained", exp_q.size(), 0);
    check_val("cont_no_overrun", ov_seen - ov0, 0);

    // Triggered: one pulse, one frame, then idle
    randomize_frame();
    exp_q.push_back(exp_word());
    pulse_start();
    count_frames(320, falls, tail);
    check_val("trig_frames", falls, 1);
    check_val("trig_idle_tail", tail >= 200, 1);
    check_val("trig_sb_drained", exp_q.size(), 0);

    // Extra start pulses during a frame merge into one pending trigger
    randomize_frame();
    exp_q.push_back(exp_word());
    exp_q.push_back(exp_word());
    pulse_start();
    wait_cs(0, 50, "merge_cs_fall");
    repeat (10) @(posedge clk); #1;
    pulse_start();
    pulse_start();
    count_frames(300, falls, tail);
    check_val("merge_frames", falls, 1);
    check_val("merge_sb_drained", exp_q.size(), 0);

    // Backpressure: first frame held, three later frames dropped
    dout_ready = 1'b0; ov0 = ov_seen;
    randomize_frame();
    a_word = exp_word();
    exp_q.push_back(a_word);
    pulse_start();
    wait_cs(0, 50, "bp_a_fall");
    wait_cs(1, 200, "bp_a_rise");
    check_val("bp_a_valid", dout_valid, 1);
    check_val("bp_a_dout", dout, a_word);
    for (int d = 0; d < 3; d++) begin
      randomize_frame();
      pulse_start();
      wait_cs(0, 50, "bp_drop_fall");
      wait_cs(1, 200, "bp_drop_rise");
      if (d == 0) begin
        check_val("bp_overrun_once", ov_seen - ov0, 1);
        check_val("bp_dout_kept", dout, a_word);
      end
    end
    check_val("bp_overrun_total", ov_seen - ov0, 3);
    check_val("bp_dout_still_a", dout, a_word);
    check_val("bp_valid_held", dout_valid, 1);
`ifdef ADC_SPI_OVERRUN_CNT_EN
    check_val("ovc_three", overrun_count, 3);
`endif

    // Accept and load in the same cycle
    randomize_frame();
    e_word = exp_word();
    exp_q.push_back(e_word);
    pulse_start();
    wait_cs(0, 50, "al_cs_fall");
    repeat (68) @(posedge clk); #1;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    check_val("al_valid", dout_valid, 1);
    check_val("al_dout_new", dout, e_word);
    check_val("al_no_overrun", overrun, 0);
    check_val("al_a_popped", exp_q.size(), 1);
    repeat (5) @(posedge clk); #1;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_val("al_sb_drained", exp_q.size(), 0);
    check_val("al_valid_cleared", dout_valid, 0);

    // Reset in the middle of shifting, with a frame waiting at the output
    dout_ready = 1'b0; cont = 1'b1;
    randomize_frame();
    wait_cs(1, 200, "mrst_idle");
    wait_cs(0, 50, "mrst_f1_fall");
    wait_cs(1, 200, "mrst_f1_rise");
    check_val("mrst_pre_valid", dout_valid, 1);
    wait_cs(0, 50, "mrst_f2_fall");
    repeat (21) @(posedge clk); #1;
    check_val("mrst_pre_sclk", sclk, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mrst_cs", cs, 1);
    check_val("mrst_sclk", sclk, 1);
    check_val("mrst_valid", dout_valid, 0);
    check_val("mrst_dout", dout, 0);
    check_val("mrst_busy", busy, 0);
    cont = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
`ifdef ADC_SPI_OVERRUN_CNT_EN
    check_val("ovc_rst", overrun_count, 0);
`endif
    repeat (30) @(posedge clk); #1;
    check_val("mrst_idle_cs", cs, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
